serial_display_receiver: RTL and testbench
==========================================

// Module: serial_display_receiver
// PURPOSE
//  Receive end of the 3-wire display link driven by the clock core (LOAD/CS, DOUT/MOSI, SCK).
//  Decodes 16-bit MAX7219-style frames into a shadow register file (8 digits plus control).
//  Used as the display-side model in system benches, and as an on-chip display controller front end.
//  Serial inputs are asynchronous to i_clk; they are synchronised and edge-detected internally.
// PARAMETERS
//  FRAME_BITS  16  bits per frame; frame = {4'bx, addr[3:0], data[7:0]}, sent MSB first
//  SYNC_STAGES 2   synchroniser depth on din/load/sck (>=2)
// PORTS
//  i_clk           in   1  system clock (~10 MHz); must be >= 4x SCK frequency
//  i_reset_n       in   1  asynchronous active-low reset
//  i_en            in   1  receive enable; low: edges ignored, FSM forced to IDLE, registers held
//  i_serial_din    in   1  serial data (MOSI), sampled on SCK rising edge
//  i_serial_load   in   1  frame strobe (CS); low = shifting, rising edge = latch
//  i_serial_clk    in   1  serial clock (SCK)
//  i_rd_digit      in   3  digit register select for o_rd_data
//  o_rd_data       out  8  digit register [i_rd_digit], combinational read
//  o_decode_mode   out  8  register 0x9
//  o_intensity     out  4  register 0xA, bits [3:0]
//  o_scan_limit    out  3  register 0xB, bits [2:0]
//  o_shutdown_n    out  1  register 0xC, bit 0 (0 = shutdown)
//  o_display_test  out  1  register 0xF, bit 0
//  o_frame_valid   out  1  one-cycle pulse: well-formed frame latched
//  o_frame_addr    out  4  address of last latched frame (held until next latch)
//  o_frame_data    out  8  data of last latched frame (held)
//  o_frame_error   out  1  one-cycle pulse: LOAD rose with bit count != FRAME_BITS
// BEHAVIOUR
//  Reset: all registers, outputs and the shift register are 0; FSM = IDLE; sync flops for load/sck
//   reset to 1/0 (idle levels). If LOAD is low at reset release, a falling edge is seen -> SHIFT.
//  Sync: SYNC_STAGES flops per input, plus one delay flop for edge detect; din uses the same depth,
//   so din is aligned with the sck edge it belongs to.
//  FSM IDLE: load_fall -> SHIFT; shift reg and bit count cleared.
//  FSM SHIFT: sck_rise -> shreg <= {shreg[FRAME_BITS-2:0], din}; count += 1, saturating at FRAME_BITS+1.
//   load_rise -> LATCH. SCK edges in IDLE are ignored.
//  FSM LATCH (1 cycle): if count == FRAME_BITS: decode addr = shreg[11:8], write register,
//   update o_frame_addr/data, pulse o_frame_valid; else pulse o_frame_error and write nothing -> IDLE.
//  Simultaneous sck_rise and load_rise in SHIFT: the bit is shifted and counted first, then LATCH.
//  Address map: 0x0 no-op (valid pulses, no write); 0x1-0x8 digit 0-7; 0x9 decode;
//   0xA intensity; 0xB scan limit; 0xC shutdown; 0xD/0xE ignored (valid pulses); 0xF display test.
//  Latency: with N = first i_clk edge where sync stage 1 captures LOAD=1 (SYNC_STAGES=2),
//   the register update and o_frame_valid/o_frame_error occur on edge N+3, exactly.
//  i_en low mid-frame: frame aborted, no pulse; the next load_fall starts a fresh frame.
//  Reset mid-frame: frame discarded, all state returns to reset values.
// STRUCTURE
//  display_pkg: register address constants (ADDR_NOOP, ADDR_DIGIT0..7, ADDR_DECODE, ADDR_INTENSITY,
//   ADDR_SCAN_LIMIT, ADDR_SHUTDOWN, ADDR_TEST), FRAME_BITS default, FSM state encoding.
//  Sub-module serial_input_sync: N-stage synchroniser with rise/fall edge-detect outputs;
//   three instances (din, load, sck). FSM, shift register and register file live in the top.
// TESTING
//  1 Reset, then frame 0x0A05 (SCK = i_clk/8) -> o_intensity=4'h5, o_frame_valid=1 for 1 cycle at N+3, addr=A, data=05.
//  2 Frames 0x0137 and 0x087F; i_rd_digit=0 -> 8'h37, i_rd_digit=7 -> 8'h7F; other digits stay 0.
//  3 15-bit frame, then 17-bit frame -> o_frame_error pulses twice, no registers change, o_frame_valid stays 0.
//  4 Frame 0x0C01, then 0x0D55 -> o_shutdown_n=1; second frame pulses valid with addr=D, no register written.
//  5 Final SCK rise and LOAD rise in the same i_clk cycle on 0x0B07 -> accepted, o_scan_limit=3'h7.
//  6 i_reset_n low after 8 bits of 0x0F01, release, send 0x0F01 -> o_display_test=1 only after the second frame.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the serial display receiver: register map, frame layout, FSM encoding.
package display_pkg;

  localparam int unsigned DEF_FRAME_BITS  = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned ADDR_W          = 4;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned NUM_DIGITS      = 8;

  localparam logic [ADDR_W-1:0] ADDR_NOOP       = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT0     = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT1     = 4'h2;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT2     = 4'h3;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT3     = 4'h4;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT4     = 4'h5;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT5     = 4'h6;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT6     = 4'h7;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT7     = 4'h8;
  localparam logic [ADDR_W-1:0] ADDR_DECODE     = 4'h9;
  localparam logic [ADDR_W-1:0] ADDR_INTENSITY  = 4'hA;
  localparam logic [ADDR_W-1:0] ADDR_SCAN_LIMIT = 4'hB;
  localparam logic [ADDR_W-1:0] ADDR_SHUTDOWN   = 4'hC;
  localparam logic [ADDR_W-1:0] ADDR_TEST       = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } rx_state_e;

  // Low 12 bits of a received frame; the top nibble is don't-care.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

  function automatic logic is_digit_addr(logic [ADDR_W-1:0] addr);
    return (addr >= ADDR_DIGIT0) && (addr <= ADDR_DIGIT7);
  endfunction

endpackage

// File: rtl/serial_input_sync.sv
// Multi-flop synchroniser for one asynchronous input, with a delay flop for rise/fall detection.
module serial_input_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/serial_display_receiver.sv
// Receive side of the 3-wire display link: shifts in 16-bit frames and decodes them
// into a digit/control register file.
module serial_display_receiver
  import display_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = DEF_FRAME_BITS,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic       i_serial_din,
  input  logic       i_serial_load,
  input  logic       i_serial_clk,
  input  logic [2:0] i_rd_digit,
  output logic [7:0] o_rd_data,
  output logic [7:0] o_decode_mode,
  output logic [3:0] o_intensity,
  output logic [2:0] o_scan_limit,
  output logic       o_shutdown_n,
  output logic       o_display_test,
  output logic       o_frame_valid,
  output logic [3:0] o_frame_addr,
  output logic [7:0] o_frame_data,
  output logic       o_frame_error
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);

  logic din_sync, din_rise, din_fall;
  logic load_sync, load_rise, load_fall;
  logic sck_sync, sck_rise, sck_fall;

  serial_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .clk_i(i_clk), .rst_ni(i_reset_n), .async_i(i_serial_din),
    .sync_o(din_sync), .rise_o(din_rise), .fall_o(din_fall)
  );

  serial_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_load (
    .clk_i(i_clk), .rst_ni(i_reset_n), .async_i(i_serial_load),
    .sync_o(load_sync), .rise_o(load_rise), .fall_o(load_fall)
  );

  serial_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i(i_clk), .rst_ni(i_reset_n), .async_i(i_serial_clk),
    .sync_o(sck_sync), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  rx_state_e              state_q, state_d;
  logic [FRAME_BITS-1:0]  shreg_q;
  logic [CNT_W-1:0]       count_q;
  logic                   clear_c, shift_c, latch_ok_c, latch_err_c;
  frame_t                 rx_frame;

  logic [DATA_W-1:0]      digits_q [NUM_DIGITS];
  logic [7:0]             decode_q;
  logic [3:0]             intensity_q;
  logic [2:0]             scan_limit_q;
  logic                   shutdown_n_q;
  logic                   display_test_q;
  logic                   frame_valid_q;
  logic                   frame_error_q;
  logic [ADDR_W-1:0]      frame_addr_q;
  logic [DATA_W-1:0]      frame_data_q;

  assign rx_frame = shreg_q[ADDR_W+DATA_W-1:0];

  // Next-state and datapath controls; a disabled receiver parks in IDLE.
  always_comb begin
    state_d     = state_q;
    clear_c     = 1'b0;
    shift_c     = 1'b0;
    latch_ok_c  = 1'b0;
    latch_err_c = 1'b0;
    if (!i_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_fall) begin
            state_d = ST_SHIFT;
            clear_c = 1'b1;
          end
        end
        ST_SHIFT: begin
          shift_c = sck_rise;
          if (load_rise) state_d = ST_LATCH;
        end
        ST_LATCH: begin
          state_d = ST_IDLE;
          if (count_q == CNT_W'(FRAME_BITS)) latch_ok_c  = 1'b1;
          else                               latch_err_c = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Shift register and saturating bit counter.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shreg_q <= '0;
      count_q <= '0;
    end else if (clear_c) begin
      shreg_q <= '0;
      count_q <= '0;
    end else if (shift_c) begin
      shreg_q <= {shreg_q[FRAME_BITS-2:0], din_sync};
      if (count_q != CNT_W'(FRAME_BITS + 1)) count_q <= count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) digits_q[i] <= '0;
      decode_q       <= '0;
      intensity_q    <= '0;
      scan_limit_q   <= '0;
      shutdown_n_q   <= 1'b0;
      display_test_q <= 1'b0;
      frame_valid_q  <= 1'b0;
      frame_error_q  <= 1'b0;
      frame_addr_q   <= '0;
      frame_data_q   <= '0;
    end else begin
      frame_valid_q <= latch_ok_c;
      frame_error_q <= latch_err_c;
      if (latch_ok_c) begin
        frame_addr_q <= rx_frame.addr;
        frame_data_q <= rx_frame.data;
        if (is_digit_addr(rx_frame.addr)) begin
          digits_q[3'(rx_frame.addr - ADDR_DIGIT0)] <= rx_frame.data;
        end
        case (rx_frame.addr)
          ADDR_DECODE:     decode_q       <= rx_frame.data;
          ADDR_INTENSITY:  intensity_q    <= rx_frame.data[3:0];
          ADDR_SCAN_LIMIT: scan_limit_q   <= rx_frame.data[2:0];
          ADDR_SHUTDOWN:   shutdown_n_q   <= rx_frame.data[0];
          ADDR_TEST:       display_test_q <= rx_frame.data[0];
          default: ;
        endcase
      end
    end
  end

  // Top nibble of the frame and the non-data sync outputs carry no information here.
  logic unused_bits;
  assign unused_bits = ^{shreg_q[FRAME_BITS-1:ADDR_W+DATA_W], din_rise, din_fall,
                         load_sync, sck_sync, sck_fall};

  assign o_rd_data      = digits_q[i_rd_digit];
  assign o_decode_mode  = decode_q;
  assign o_intensity    = intensity_q;
  assign o_scan_limit   = scan_limit_q;
  assign o_shutdown_n   = shutdown_n_q;
  assign o_display_test = display_test_q;
  assign o_frame_valid  = frame_valid_q;
  assign o_frame_error  = frame_error_q;
  assign o_frame_addr   = frame_addr_q;
  assign o_frame_data   = frame_data_q;

endmodule

// File: tb/tb_serial_display_receiver.sv
// Bench for serial_display_receiver: frame table with expected register state, plus a
// pulse scoreboard that checks kind, payload and exact latency of every latch.
module tb_serial_display_receiver;

  logic       clk = 1'b0;
  logic       i_reset_n;
  logic       i_en;
  logic       i_serial_din;
  logic       i_serial_load;
  logic       i_serial_clk;
  logic [2:0] i_rd_digit;
  logic [7:0] o_rd_data;
  logic [7:0] o_decode_mode;
  logic [3:0] o_intensity;
  logic [2:0] o_scan_limit;
  logic       o_shutdown_n;
  logic       o_display_test;
  logic       o_frame_valid;
  logic [3:0] o_frame_addr;
  logic [7:0] o_frame_data;
  logic       o_frame_error;

  serial_display_receiver dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_en(i_en),
    .i_serial_din(i_serial_din), .i_serial_load(i_serial_load), .i_serial_clk(i_serial_clk),
    .i_rd_digit(i_rd_digit), .o_rd_data(o_rd_data),
    .o_decode_mode(o_decode_mode), .o_intensity(o_intensity), .o_scan_limit(o_scan_limit),
    .o_shutdown_n(o_shutdown_n), .o_display_test(o_display_test),
    .o_frame_valid(o_frame_valid), .o_frame_addr(o_frame_addr),
    .o_frame_data(o_frame_data), .o_frame_error(o_frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit         err;
    logic [3:0] addr;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t exp_q[$];

  // Every pulse must match the oldest expectation, on exactly its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (o_frame_valid || o_frame_error) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 64'({o_frame_valid, o_frame_error}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 64'({o_frame_valid, o_frame_error}), e.err ? 64'd1 : 64'd2);
        check("pulse_cycle", 64'(cyc), 64'(e.due));
        if (!e.err) check("frame_addr_data", 64'({o_frame_addr, o_frame_data}), 64'({e.addr, e.data}));
      end
    end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      check("pulse_missing", 64'({o_frame_valid, o_frame_error}), e.err ? 64'd1 : 64'd2);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SCK = clk/8; last bit optionally raises SCK and LOAD together.
  task automatic shift_bits(input logic [31:0] bits, input int nbits, input bit merge_last);
    for (int i = nbits - 1; i >= 0; i--) begin
      i_serial_din = bits[i];
      i_serial_clk = 1'b0;
      wait_clk(4);
      i_serial_clk = 1'b1;
      if (merge_last && i == 0) i_serial_load = 1'b1;
      else                      wait_clk(4);
    end
  endtask

  task automatic send_frame(input logic [31:0] bits, input int nbits, input bit merge);
    exp_t e;
    i_serial_load = 1'b0;
    wait_clk(4);
    shift_bits(bits, nbits, merge);
    if (!merge) begin
      i_serial_clk = 1'b0;
      wait_clk(4);
      i_serial_load = 1'b1;
    end
    e.err  = (nbits != 16);
    e.addr = bits[11:8];
    e.data = bits[7:0];
    e.due  = cyc + 4;
    exp_q.push_back(e);
    wait_clk(4);
    i_serial_clk = 1'b0;
    wait_clk(8);
  endtask

  task automatic read_digit(input int d, output logic [7:0] v);
    i_rd_digit = 3'(d);
    #1;
    v = o_rd_data;
  endtask

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    bit          merge;
    logic [7:0]  decode;
    logic [3:0]  inten;
    logic [2:0]  scan;
    logic        shut;
    logic        test;
    logic [7:0]  d0;
    logic [7:0]  d7;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] d0, d7, dv;

    //         bits         n   mg  decode inten scan shut test d0     d7
    vecs[0] = '{32'h0A05,   16, 0,  8'h00, 4'h5, 3'h0, 0,  0,  8'h00, 8'h00};
    vecs[1] = '{32'h0137,   16, 0,  8'h00, 4'h5, 3'h0, 0,  0,  8'h37, 8'h00};
    vecs[2] = '{32'h087F,   16, 0,  8'h00, 4'h5, 3'h0, 0,  0,  8'h37, 8'h7F};
    vecs[3] = '{32'h0AFF,   15, 0,  8'h00, 4'h5, 3'h0, 0,  0,  8'h37, 8'h7F};
    vecs[4] = '{32'h00AFF,  17, 0,  8'h00, 4'h5, 3'h0, 0,  0,  8'h37, 8'h7F};
    vecs[5] = '{32'h0C01,   16, 0,  8'h00, 4'h5, 3'h0, 1,  0,  8'h37, 8'h7F};
    vecs[6] = '{32'h0D55,   16, 0,  8'h00, 4'h5, 3'h0, 1,  0,  8'h37, 8'h7F};
    vecs[7] = '{32'h0B07,   16, 1,  8'h00, 4'h5, 3'h7, 1,  0,  8'h37, 8'h7F};
    vecs[8] = '{32'h09F0,   16, 0,  8'hF0, 4'h5, 3'h7, 1,  0,  8'h37, 8'h7F};
    vecs[9] = '{32'h0000,   16, 0,  8'hF0, 4'h5, 3'h7, 1,  0,  8'h37, 8'h7F};

    i_reset_n = 1'b0; i_en = 1'b1; i_serial_din = 1'b0;
    i_serial_load = 1'b1; i_serial_clk = 1'b0; i_rd_digit = 3'd0;
    wait_clk(4);
    check("reset_outputs", 64'({o_rd_data, o_decode_mode, o_intensity, o_scan_limit, o_shutdown_n,
                                o_display_test, o_frame_valid, o_frame_addr, o_frame_data, o_frame_error}), 64'd0);
    i_reset_n = 1'b1;
    wait_clk(6);

    foreach (vecs[i]) begin
      send_frame(vecs[i].bits, vecs[i].nbits, vecs[i].merge);
      read_digit(0, d0);
      read_digit(7, d7);
      check($sformatf("regs_vec%0d", i),
            64'({o_decode_mode, o_intensity, o_scan_limit, o_shutdown_n, o_display_test, d0, d7}),
            64'({vecs[i].decode, vecs[i].inten, vecs[i].scan, vecs[i].shut, vecs[i].test, vecs[i].d0, vecs[i].d7}));
      if (vecs[i].nbits != 16)
        check("frame_held_after_error", 64'({o_frame_addr, o_frame_data}), 64'({4'h8, 8'h7F}));
    end

    for (int d = 1; d < 7; d++) begin
      read_digit(d, dv);
      check($sformatf("digit%0d_untouched", d), 64'(dv), 64'd0);
    end

    // Receiver disabled mid-frame: the frame is dropped without any pulse.
    i_serial_load = 1'b0;
    wait_clk(4);
    shift_bits(32'h0A, 8, 1'b0);
    i_en = 1'b0;
    shift_bits(32'h0F, 8, 1'b0);
    i_serial_clk = 1'b0;
    wait_clk(4);
    i_serial_load = 1'b1;
    wait_clk(8);
    i_en = 1'b1;
    wait_clk(8);
    check("en_abort_intensity", 64'(o_intensity), 64'h5);
    send_frame(32'h0A03, 16, 1'b0);
    check("after_abort_intensity", 64'(o_intensity), 64'h3);

    // Reset mid-frame discards the partial frame and all registers.
    i_serial_load = 1'b0;
    wait_clk(4);
    shift_bits(32'h0F, 8, 1'b0);
    i_reset_n = 1'b0;
    i_serial_load = 1'b1; i_serial_clk = 1'b0; i_serial_din = 1'b0;
    wait_clk(4);
    i_reset_n = 1'b1;
    wait_clk(8);
    read_digit(0, d0);
    check("midframe_reset_regs", 64'({o_decode_mode, o_intensity, o_scan_limit, o_shutdown_n, o_display_test, d0}), 64'd0);
    send_frame(32'h0F01, 16, 1'b0);
    check("display_test_after_frame", 64'(o_display_test), 64'd1);

    wait_clk(10);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
